// File: rtl/gat_pkg.sv
// Shared GAT accelerator definitions: feature BRAM geometry and readout FSM states.
package gat_pkg;

  localparam int NEW_FEATURE_NODES = 2708;
  localparam int NEW_FEATURE_DIM   = 16;
  localparam int NEW_FEATURE_DEPTH = NEW_FEATURE_NODES * NEW_FEATURE_DIM;
  localparam int NEW_FEATURE_WIDTH = 32;
  localparam int BYTE_ADDR_SHIFT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } feat_rd_state_t;

endpackage

// File: rtl/gat_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and registered occupancy count.
module gat_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gat_feat_streamer.sv
// Walks the new-feature BRAM (port B) after gat_ready and streams the words out
// as valid/ready with a last marker, hiding the fixed BRAM read latency.
module gat_feat_streamer #(
  parameter int NEW_FEATURE_WIDTH  = gat_pkg::NEW_FEATURE_WIDTH,
  parameter int NEW_FEATURE_DEPTH  = gat_pkg::NEW_FEATURE_DEPTH,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done
);
  import gat_pkg::*;

  localparam int AW = NEW_FEATURE_ADDR_W;
  localparam int L  = BRAM_RD_LATENCY;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  feat_rd_state_t state;
  logic [AW:0]    total, rd_idx, num_sat;
  logic [AW+1:0]  addr_q, issue_addr;
  logic [L:1]     vld_pipe, last_pipe;
  logic [CW-1:0]  inflight, fifo_count;
  logic [CW:0]    credit;
  logic           fifo_empty, fifo_full, issue, pop, rd_last, last_seen;

  assign num_sat = (num_words > (AW+1)'(NEW_FEATURE_DEPTH)) ? (AW+1)'(NEW_FEATURE_DEPTH) : num_words;

  // Reads in flight plus buffered words never exceed the FIFO, so a push always fits.
  assign credit     = (CW+1)'(inflight) + (CW+1)'(fifo_count);
  assign issue      = (state == ST_READ) && (credit < (CW+1)'(FIFO_DEPTH)) && !fifo_full;
  assign rd_last    = (rd_idx == total - 1'b1);
  assign issue_addr = (AW+2)'(rd_idx[AW-1:0]) << BYTE_ADDR_SHIFT;

  // The address is presented in the issue cycle itself and held otherwise.
  assign feat_bram_addrb = issue ? issue_addr : addr_q;

  assign m_tvalid = !fifo_empty;
  assign pop      = m_tvalid & m_tready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FINISH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      total     <= '0;
      rd_idx    <= '0;
      addr_q    <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      inflight  <= '0;
      last_seen <= 1'b0;
    end else begin
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue & rd_last;
      for (int k = 2; k <= L; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end

      case ({issue, vld_pipe[L]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase

      if (issue) begin
        addr_q <= issue_addr;
        rd_idx <= rd_idx + 1'b1;
      end
      if (pop && m_tlast) last_seen <= 1'b1;

      case (state)
        ST_IDLE: if (start) begin
          total     <= num_sat;
          rd_idx    <= '0;
          last_seen <= 1'b0;
          state     <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: if (gat_ready) state <= (total == '0) ? ST_FINISH : ST_READ;
        ST_READ:     if (issue && rd_last) state <= ST_DRAIN;
        ST_DRAIN:    if (fifo_empty && inflight == '0 && last_seen) state <= ST_FINISH;
        ST_FINISH:   state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  gat_sync_fifo #(
    .WIDTH (NEW_FEATURE_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_pipe[L]),
    .din   ({last_pipe[L], feat_bram_dout}),
    .pop   (pop),
    .dout  ({m_tlast, m_tdata}),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule
